// File: rtl/windower_frame_ctrl_pkg.sv
// Shared types and helpers for the windower front-end frame sequencer.
// Contents: default parameter values, frame state enum, frame-length helper.
package windower_frame_ctrl_pkg;

  localparam int unsigned DEF_NO_CH         = 2;
  localparam int unsigned DEF_LOG2_IMG_SIZE = 10;
  localparam int unsigned DEF_THROUGHPUT    = 1;
  localparam int unsigned DEF_DRAIN_CYCLES  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } frame_state_t;

  // Words per frame: samples per frame divided by lanes per word.
  function automatic int unsigned frame_words(input int unsigned log2_img_size,
                                              input int unsigned throughput);
    return 32'(1) << (log2_img_size - 32'($clog2(throughput)));
  endfunction

endpackage

// File: rtl/windower_frame_ctrl_if.sv
// Sample-source and windower-side signals of the frame sequencer.
// Source side: s_valid/s_data in, s_ready out (ready/valid).
// Windower side: win_rst, win_vld_in, win_data driven by the sequencer.
// master = testbench/source+sink view, slave = sequencer view.
interface windower_frame_ctrl_if #(
  parameter int unsigned NO_CH      = 2,
  parameter int unsigned THROUGHPUT = 1
) ();

  logic                                 s_valid;
  logic                                 s_ready;
  logic [THROUGHPUT-1:0][NO_CH-1:0]     s_data;
  logic                                 win_rst;
  logic                                 win_vld_in;
  logic [THROUGHPUT-1:0][NO_CH-1:0]     win_data;

  modport master (
    output s_valid, s_data,
    input  s_ready, win_rst, win_vld_in, win_data
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, win_rst, win_vld_in, win_data
  );

endinterface

// File: rtl/windower_frame_ctrl_sync_fifo.sv
// Synchronous FIFO with registered occupancy count and synchronous flush.
// Ports: clk, rst (sync, active-high), flush (drop contents), push/wdata,
//        pop/rdata (rdata shows the head word combinationally), count.
// DEPTH must be a power of 2 and >= 2.
module sync_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != CW'(DEPTH)) && !flush && !rst;
  assign do_pop  = pop  && (count != '0) && !flush && !rst;
  assign rdata   = mem[rd_ptr];

  // Pointers and occupancy; flush behaves like a reset of the queue state.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed: pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/windower_frame_ctrl.sv
// Front-end sequencer for the windower: buffers the I/Q stream and releases
// only whole frames on consecutive cycles, then waits out the windower tail.
// Ports: clk, rst (sync, active-high), en (allow new frames), flush (abort),
//        bus (slave modport: s_valid/s_ready/s_data, win_rst/win_vld_in/win_data),
//        frame_start, frame_done (pulses), busy, fill (FIFO occupancy),
//        frames_sent (completed frames, wraps at 2**16).
module windower_frame_ctrl
  import windower_frame_ctrl_pkg::*;
#(
  parameter int unsigned NO_CH         = DEF_NO_CH,
  parameter int unsigned LOG2_IMG_SIZE = DEF_LOG2_IMG_SIZE,
  parameter int unsigned THROUGHPUT    = DEF_THROUGHPUT,
  parameter int unsigned DEPTH         = 2 * frame_words(LOG2_IMG_SIZE, THROUGHPUT),
  parameter int unsigned DRAIN_CYCLES  = DEF_DRAIN_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    flush,
  windower_frame_ctrl_if.slave    bus,
  output logic                    frame_start,
  output logic                    frame_done,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fill,
  output logic [15:0]             frames_sent
);

  localparam int unsigned FW    = frame_words(LOG2_IMG_SIZE, THROUGHPUT);
  localparam int unsigned WIDTH = THROUGHPUT * NO_CH;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned WCW   = $clog2(FW + 1);
  localparam int unsigned DCW   = $clog2(DRAIN_CYCLES + 1);

  typedef logic [THROUGHPUT-1:0][NO_CH-1:0] word_t;

  frame_state_t     state;
  logic [WCW-1:0]   word_cnt;
  logic [DCW-1:0]   drain_cnt;
  logic             win_rst_q;
  logic             rst_d;
  logic             win_vld_q;
  word_t            win_data_q;
  logic [WIDTH-1:0] fifo_rdata;
  logic             push;
  logic             pop;

  // Ready comes from the registered count, so it never depends on s_valid.
  assign bus.s_ready = (fill != CW'(DEPTH));
  assign push        = bus.s_valid && bus.s_ready;
  assign pop         = (state == STREAM);

  assign bus.win_rst    = win_rst_q;
  assign bus.win_vld_in = win_vld_q;
  assign bus.win_data   = win_data_q;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata (WIDTH'(bus.s_data)),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fill)
  );

  // Frame FSM with counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      word_cnt    <= '0;
      drain_cnt   <= '0;
      win_vld_q   <= 1'b0;
      win_data_q  <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      frames_sent <= '0;
      win_rst_q   <= 1'b1;
      rst_d       <= 1'b1;
    end else begin
      // Windower reset is stretched one cycle past rst, and pulsed on flush.
      rst_d       <= 1'b0;
      win_rst_q   <= flush || rst_d;
      win_vld_q   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      if (flush) begin
        state     <= IDLE;
        busy      <= 1'b0;
        word_cnt  <= '0;
        drain_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (en && (fill >= CW'(FW))) begin
              state    <= STREAM;
              busy     <= 1'b1;
              word_cnt <= '0;
            end
          end
          STREAM: begin
            // The head popped this cycle is presented to the windower next cycle.
            win_vld_q   <= 1'b1;
            win_data_q  <= word_t'(fifo_rdata);
            frame_start <= (word_cnt == '0);
            if (word_cnt == WCW'(FW - 1)) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end else begin
              word_cnt <= word_cnt + WCW'(1);
            end
          end
          DRAIN: begin
            if (drain_cnt == DCW'(DRAIN_CYCLES - 1)) begin
              state       <= IDLE;
              busy        <= 1'b0;
              frame_done  <= 1'b1;
              frames_sent <= frames_sent + 16'd1;
            end else begin
              drain_cnt <= drain_cnt + DCW'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_windower_frame_ctrl.sv
// Scoreboard bench for windower_frame_ctrl: the driver queues every accepted
// word, and a negedge monitor checks output data, framing pulses, frame count
// and FIFO occupancy against bench-side models.
module tb_windower_frame_ctrl;
  import windower_frame_ctrl_pkg::*;

  localparam int unsigned NO_CH = 8;
  localparam int unsigned LOG2  = 4;
  localparam int unsigned TP    = 1;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned DRAIN = 3;
  localparam int unsigned FW    = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          flush;
  logic          frame_start;
  logic          frame_done;
  logic          busy;
  logic [CW-1:0] fill;
  logic [15:0]   frames_sent;

  windower_frame_ctrl_if #(.NO_CH(NO_CH), .THROUGHPUT(TP)) bus ();

  windower_frame_ctrl #(
    .NO_CH         (NO_CH),
    .LOG2_IMG_SIZE (LOG2),
    .THROUGHPUT    (TP),
    .DEPTH         (DEPTH),
    .DRAIN_CYCLES  (DRAIN)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .flush       (flush),
    .bus         (bus.slave),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .busy        (busy),
    .fill        (fill),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         acc_cnt    = 0;
  bit         fill_clr   = 1'b0;
  bit         abort_req  = 1'b0;
  bit         mon_hold   = 1'b1;
  int         fill_exp   = 0;
  int         frames_exp = 0;
  int         run        = 0;
  int         gap        = 0;
  bit         pending    = 1'b0;
  bit         last_ok    = 1'b0;
  bit         exp_done;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_models();
    exp_q.delete();
    acc_cnt    = 0;
    fill_clr   = 1'b0;
    abort_req  = 1'b0;
    fill_exp   = 0;
    frames_exp = 0;
    run        = 0;
    gap        = 0;
    pending    = 1'b0;
    last_ok    = 1'b0;
  endtask

  // Offer one word; it is queued as expected output only once accepted.
  task automatic push_word(input logic [7:0] d);
    bit rdy;
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    do begin
      rdy = bus.s_ready;
      tick();
      n++;
    end while (!rdy && n < 300);
    if (rdy) begin
      exp_q.push_back(d);
      acc_cnt++;
    end else begin
      check("push_timeout", 0, 1);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int quiet;
    int n;
    quiet = 0;
    n     = 0;
    while (quiet < 6 && n < 3000) begin
      tick();
      n++;
      if (busy || bus.win_vld_in) quiet = 0;
      else quiet++;
    end
    check("idle_reached", int'(quiet >= 6), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vld"},         int'(bus.win_vld_in), 0);
    check({tag, "_start"},       int'(frame_start), 0);
    check({tag, "_done"},        int'(frame_done), 0);
    check({tag, "_busy"},        int'(busy), 0);
    check({tag, "_fill"},        int'(fill), 0);
    check({tag, "_data"},        int'(bus.win_data), 0);
    check({tag, "_frames_sent"}, int'(frames_sent), 0);
    check({tag, "_win_rst"},     int'(bus.win_rst), 1);
  endtask

  // Monitor: scoreboard pop on every valid output plus framing/occupancy models.
  always @(negedge clk) begin
    if (!mon_hold) begin
      if (fill_clr) begin
        fill_exp = 0;
        fill_clr = 1'b0;
      end else begin
        fill_exp = fill_exp + acc_cnt - (bus.win_vld_in ? 1 : 0);
      end
      acc_cnt = 0;
      check("fill", int'(fill), fill_exp);
      check("no_underflow", int'(u_dut.state == STREAM && fill == '0), 0);
      if (bus.win_vld_in) begin
        if (run == 0 && last_ok) check("frame_gap_min", int'(gap >= int'(DRAIN + 1)), 1);
        check("frame_start", int'(frame_start), int'(run == 0));
        if (exp_q.size() == 0) check("data_unexpected", 1, 0);
        else check("data", int'(bus.win_data), int'(exp_q.pop_front()));
        run++;
        gap = 0;
      end else begin
        check("frame_start_idle", int'(frame_start), 0);
        if (run != 0) begin
          if (abort_req) begin
            abort_req = 1'b0;
            last_ok   = 1'b0;
          end else begin
            check("frame_len", run, int'(FW));
            pending = 1'b1;
            last_ok = 1'b1;
          end
          run = 0;
        end
        gap++;
      end
      exp_done = pending && (gap == int'(DRAIN));
      if (exp_done) begin
        pending = 1'b0;
        frames_exp++;
      end
      check("frame_done", int'(frame_done), int'(exp_done));
      check("frames_sent", int'(frames_sent), frames_exp);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst         = 1'b1;
    en          = 1'b0;
    flush       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    check("reset_s_ready", int'(bus.s_ready), 1);
    rst = 1'b0;
    tick();
    check("win_rst_stretch", int'(bus.win_rst), 1);
    tick();
    check("win_rst_release", int'(bus.win_rst), 0);
    reset_models();
    mon_hold = 1'b0;

    // 1: one whole frame
    en = 1'b1;
    for (int i = 0; i < 16; i++) push_word(8'(i));
    wait_idle();
    check("t1_frames_sent", int'(frames_sent), 1);

    // 2: 15 words hold, 16th releases the frame two cycles later
    for (int i = 16; i < 31; i++) push_word(8'(i));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_no_frame", int'(bus.win_vld_in || busy), 0);
    end
    push_word(8'd31);
    check("t2_lat0", int'(bus.win_vld_in), 0);
    tick();
    check("t2_lat1", int'(bus.win_vld_in), 0);
    tick();
    check("t2_lat2", int'(bus.win_vld_in), 1);
    wait_idle();

    // 3: fill to DEPTH with en low, then two frames
    en = 1'b0;
    for (int i = 32; i < 64; i++) push_word(8'(i));
    check("t3_full", int'(fill), 32);
    check("t3_s_ready", int'(bus.s_ready), 0);
    check("t3_en_hold", int'(busy), 0);
    en = 1'b1;
    for (int i = 64; i < 72; i++) push_word(8'(i));
    wait_idle();
    check("t3_fill_end", int'(fill), 8);
    check("t3_frames_sent", int'(frames_sent), 4);

    // 4: continuous input across four frames
    for (int i = 72; i < 136; i++) push_word(8'(i));
    wait_idle();
    check("t4_fill_end", int'(fill), 8);
    check("t4_frames_sent", int'(frames_sent), 8);

    // 5: flush at word 7, then a clean frame
    for (int i = 136; i < 144; i++) push_word(8'(i));
    n = 0;
    while (!frame_start && n < 100) begin
      tick();
      n++;
    end
    check("t5_frame_started", int'(frame_start), 1);
    repeat (7) tick();
    flush       = 1'b1;
    abort_req   = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hAA;
    tick();
    flush       = 1'b0;
    bus.s_valid = 1'b0;
    fill_clr    = 1'b1;
    exp_q.delete();
    check("t5_vld", int'(bus.win_vld_in), 0);
    check("t5_win_rst", int'(bus.win_rst), 1);
    check("t5_fill", int'(fill), 0);
    check("t5_busy", int'(busy), 0);
    tick();
    check("t5_win_rst_pulse", int'(bus.win_rst), 0);
    for (int i = 144; i < 160; i++) push_word(8'(i));
    wait_idle();
    check("t5_frames_sent", int'(frames_sent), 9);

    // 6: reset during DRAIN
    for (int i = 160; i < 176; i++) push_word(8'(i));
    n = 0;
    while (!bus.win_vld_in && n < 100) begin
      tick();
      n++;
    end
    while (bus.win_vld_in && n < 200) begin
      tick();
      n++;
    end
    check("t6_in_drain", int'(busy && !bus.win_vld_in), 1);
    mon_hold = 1'b1;
    rst      = 1'b1;
    tick();
    check_reset_outputs("t6");
    rst = 1'b0;
    tick();
    check("t6_win_rst_stretch", int'(bus.win_rst), 1);
    tick();
    reset_models();
    mon_hold = 1'b0;
    repeat (10) tick();
    check("t6_frames_after", int'(frames_sent), 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
